// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared codes, state encoding and helpers for the data memory controller
package dmem_pkg;

    // Load codes as presented on load_code
    localparam logic [2:0] LC_LB  = 3'b000;
    localparam logic [2:0] LC_LH  = 3'b001;
    localparam logic [2:0] LC_LW  = 3'b010;
    localparam logic [2:0] LC_LBU = 3'b100;
    localparam logic [2:0] LC_LHU = 3'b101;

    // Store codes as presented on store_code
    localparam logic [1:0] SC_SB = 2'b00;
    localparam logic [1:0] SC_SH = 2'b01;
    localparam logic [1:0] SC_SW = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BEAT = 2'b01,
        ST_CAPT = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Loads and stores share the size field in the low two code bits
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Store codes are carried internally as {1'b0, store_code}
    function automatic logic code_illegal(input logic we, input logic [2:0] code);
        if (we)
            return (code[1:0] == 2'b11);
        return (code == 3'b011) || (code[2:1] == 2'b11);
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] code, input logic [31:0] raw);
        case (code)
            LC_LB:   return {{24{raw[7]}}, raw[7:0]};
            LC_LH:   return {{16{raw[15]}}, raw[15:0]};
            LC_LW:   return raw;
            LC_LBU:  return {24'h0, raw[7:0]};
            LC_LHU:  return {16'h0, raw[15:0]};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - per-master request/response bundle of the data memory controller
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  load_code;
    logic [1:0]  store_code;
    logic        gnt;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, load_code, store_code,
        input  gnt, done, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, load_code, store_code,
        output gnt, done, rdata, err
    );
endinterface

// File: rtl/dmem_ctrl_rr_arb2.sv
// rtl/dmem_ctrl_rr_arb2.sv - two-way round-robin arbiter, master 0 favoured after reset
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last;

    // Grant the sole requester, or the one not granted last when both ask
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    // Remember which master was granted most recently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= 1'b1;
        else if (|o_gnt)
            r_last <= o_gnt[1];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - two-master byte-serialising controller for the core data RAM
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_ctrl_if.slave        m0,
    dmem_ctrl_if.slave        m1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [7:0]        ram_rdata
);

    state_e            r_state;
    state_e            w_next;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_arb_en;
    logic              w_sel;
    logic              w_we;
    logic [2:0]        w_code;
    logic              w_ill;
    logic              w_last;
    logic [31:0]       w_raw;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_code;
    logic              r_mid;
    logic [2:0]        r_n;
    logic [2:0]        r_beat;
    logic [31:0]       r_raw;
    logic              r_cap_pend;
    logic [1:0]        r_cap_idx;
    logic [31:0]       r_rdata [2];
    logic [1:0]        r_err;

    assign w_req    = {m1.req, m0.req};
    assign w_arb_en = (r_state == ST_IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_arb_en),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign w_sel  = w_gnt[1];
    assign w_we   = w_sel ? m1.we : m0.we;
    assign w_code = w_we ? {1'b0, (w_sel ? m1.store_code : m0.store_code)}
                         : (w_sel ? m1.load_code : m0.load_code);
    assign w_ill  = code_illegal(w_we, w_code);
    assign w_last = (r_beat == r_n - 3'd1);

    assign m0.gnt   = w_gnt[0];
    assign m1.gnt   = w_gnt[1];
    assign m0.done  = (r_state == ST_RESP) && !r_mid;
    assign m1.done  = (r_state == ST_RESP) && r_mid;
    assign m0.rdata = r_rdata[0];
    assign m1.rdata = r_rdata[1];
    assign m0.err   = r_err[0];
    assign m1.err   = r_err[1];

    // Load bytes gathered so far, with the byte arriving this cycle merged in
    always_comb begin
        w_raw = r_raw;
        if (r_cap_pend)
            w_raw[{r_cap_idx, 3'b000} +: 8] = ram_rdata;
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and RAM strobe decode
    always_comb begin
        w_next    = r_state;
        ram_addr  = '0;
        ram_wdata = 8'h00;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_gnt)
                    w_next = w_ill ? ST_RESP : ST_BEAT;
            end
            ST_BEAT: begin
                ram_addr = r_addr + ADDR_W'(r_beat);
                ram_we   = r_we;
                ram_re   = !r_we;
                if (r_we)
                    ram_wdata = r_wdata[{r_beat[1:0], 3'b000} +: 8];
                if (w_last)
                    w_next = r_we ? ST_RESP : ST_CAPT;
            end
            ST_CAPT: w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch, beat counter, load assembly and per-master results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_code     <= 3'b000;
            r_mid      <= 1'b0;
            r_n        <= 3'd1;
            r_beat     <= 3'd0;
            r_raw      <= 32'h0;
            r_cap_pend <= 1'b0;
            r_cap_idx  <= 2'd0;
            r_rdata[0] <= 32'h0;
            r_rdata[1] <= 32'h0;
            r_err      <= 2'b00;
        end else begin
            // A read strobe this cycle means its byte is on ram_rdata next cycle
            r_cap_pend <= (r_state == ST_BEAT) && !r_we;
            r_cap_idx  <= r_beat[1:0];
            if (r_cap_pend)
                r_raw[{r_cap_idx, 3'b000} +: 8] <= ram_rdata;

            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_we    <= w_we;
                        r_addr  <= w_sel ? m1.addr[ADDR_W-1:0] : m0.addr[ADDR_W-1:0];
                        r_wdata <= w_sel ? m1.wdata : m0.wdata;
                        r_code  <= w_code;
                        r_mid   <= w_sel;
                        r_n     <= beat_count(w_code[1:0]);
                        r_beat  <= 3'd0;
                        r_raw   <= 32'h0;
                        if (w_ill) begin
                            r_rdata[w_sel] <= 32'h0;
                            r_err[w_sel]   <= 1'b1;
                        end
                    end
                end
                ST_BEAT: begin
                    r_beat <= r_beat + 3'd1;
                    if (w_last && r_we) begin
                        r_rdata[r_mid] <= 32'h0;
                        r_err[r_mid]   <= 1'b0;
                    end
                end
                ST_CAPT: begin
                    r_rdata[r_mid] <= extend(r_code, w_raw);
                    r_err[r_mid]   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a byte-array reference model
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_ctrl_if m0_if ();
    dmem_ctrl_if m1_if ();

    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we, ram_re;

    dmem_ctrl #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata)
    );

    logic [1:0]  t_req = 2'b00;
    logic [1:0]  t_we = 2'b00;
    logic [31:0] t_addr [2];
    logic [31:0] t_wdata [2];
    logic [2:0]  t_lc [2];
    logic [1:0]  t_sc [2];

    assign m0_if.req = t_req[0];         assign m1_if.req = t_req[1];
    assign m0_if.we = t_we[0];           assign m1_if.we = t_we[1];
    assign m0_if.addr = t_addr[0];       assign m1_if.addr = t_addr[1];
    assign m0_if.wdata = t_wdata[0];     assign m1_if.wdata = t_wdata[1];
    assign m0_if.load_code = t_lc[0];    assign m1_if.load_code = t_lc[1];
    assign m0_if.store_code = t_sc[0];   assign m1_if.store_code = t_sc[1];

    wire [1:0] o_gnt  = {m1_if.gnt, m0_if.gnt};
    wire [1:0] o_done = {m1_if.done, m0_if.done};
    wire [1:0] o_err  = {m1_if.err, m0_if.err};
    logic [31:0] o_rdata [2];
    assign o_rdata[0] = m0_if.rdata;
    assign o_rdata[1] = m1_if.rdata;

    // Synchronous single-port RAM with one-cycle read latency
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    // Log of RAM strobes as seen mid-cycle
    logic       ev_w [$];
    logic [7:0] ev_a [$];
    logic [7:0] ev_d [$];
    always @(negedge clk) begin
        if (ram_we || ram_re) begin
            ev_w.push_back(ram_we);
            ev_a.push_back(ram_addr);
            ev_d.push_back(ram_wdata);
        end
    end

    logic [7:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_illegal(input bit we, input logic [2:0] lc, input logic [1:0] sc);
        if (we) return sc == 2'd3;
        return (lc == 3'd3) || (lc == 3'd6) || (lc == 3'd7);
    endfunction

    function automatic int ref_bytes(input bit we, input logic [2:0] lc, input logic [1:0] sc);
        int sz;
        sz = we ? int'(sc) : int'(lc % 4);
        return 1 << sz;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] lc, input logic [31:0] addr);
        longint v = 0;
        int n = ref_bytes(1'b0, lc, 2'd0);
        for (int i = 0; i < n; i++)
            v += longint'(ref_mem[(addr + i) % 256]) << (8 * i);
        if (lc == 3'd0 && v >= 128)   v -= 256;
        if (lc == 3'd1 && v >= 32768) v -= 65536;
        return v[31:0];
    endfunction

    function automatic void ref_store(input logic [1:0] sc, input logic [31:0] addr, input logic [31:0] wd);
        int n = 1 << sc;
        for (int i = 0; i < n; i++)
            ref_mem[(addr + i) % 256] = wd[8*i +: 8];
    endfunction

    // Strobes logged since the last clear must match the reference beat sequence
    task automatic chk_events(input string tag, input bit we, input logic [31:0] addr,
                              input logic [31:0] wd, input int n);
        chk({tag, " beats"}, ev_w.size(), n);
        for (int i = 0; i < n && i < ev_w.size(); i++) begin
            chk({tag, " beat we"}, ev_w[i], we);
            chk({tag, " beat addr"}, ev_a[i], (addr + i) % 256);
            if (we) chk({tag, " beat data"}, ev_d[i], wd[8*i +: 8]);
        end
    endtask

    task automatic clear_events();
        ev_w.delete(); ev_a.delete(); ev_d.delete();
    endtask

    // Waits for done on master m, counting cycles after the grant cycle
    task automatic wait_done(input int m, input string tag, output int lat);
        bit seen = 0;
        bit other = 0;
        lat = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (o_done[1-m]) other = 1;
            if (o_done[m]) seen = 1;
        end
        chk({tag, " done"}, seen, 1);
        chk({tag, " other done"}, other, 0);
    endtask

    task automatic set_req(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] lc, input logic [1:0] sc);
        t_we[m] = we; t_addr[m] = addr; t_wdata[m] = wd; t_lc[m] = lc; t_sc[m] = sc;
        t_req[m] = 1'b1;
    endtask

    // One complete access through master m, fully checked against the reference model
    task automatic access(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] lc, input logic [1:0] sc, input string tag,
                          output logic [31:0] rd);
        int w = 0;
        int lat;
        bit ill = ref_illegal(we, lc, sc);
        int n = ref_bytes(we, lc, sc);
        logic [31:0] exp_rd;
        @(negedge clk);
        clear_events();
        set_req(m, we, addr, wd, lc, sc);
        #1;
        while (!o_gnt[m] && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk({tag, " gnt"}, o_gnt[m], 1);
        @(posedge clk); #1;
        t_req[m] = 1'b0;
        wait_done(m, tag, lat);
        exp_rd = (ill || we) ? 32'h0 : ref_load(lc, addr);
        chk({tag, " latency"}, lat, ill ? 1 : (we ? n + 1 : n + 2));
        chk({tag, " rdata"}, o_rdata[m], exp_rd);
        chk({tag, " err"}, o_err[m], ill);
        chk_events(tag, we, addr, wd, ill ? 0 : n);
        if (we && !ill) ref_store(sc, addr, wd);
        rd = o_rdata[m];
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        for (int i = 0; i < 2; i++) begin
            t_addr[i] = 0; t_wdata[i] = 0; t_lc[i] = 0; t_sc[i] = 0;
        end

        // Reset state
        #12;
        chk("rst gnt", o_gnt, 0);
        chk("rst done", o_done, 0);
        chk("rst err", o_err, 0);
        chk("rst rdata0", o_rdata[0], 0);
        chk("rst rdata1", o_rdata[1], 0);
        chk("rst strobes", {ram_we, ram_re}, 0);
        chk("rst addr", ram_addr, 0);
        chk("rst wdata", ram_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the RAM with random words; upper address bits must be ignored
        for (int a = 0; a < 256; a += 4)
            access((a / 4) % 2, 1'b1, {$urandom_range(0, 255), 24'h0} | a, $urandom,
                   3'd0, SC_SW, "fill", rd);

        // Word load timing and assembly
        access(0, 1'b1, 32'h10, 32'hFE017F80, 3'd0, SC_SW, "t1 sw", rd);
        access(0, 1'b0, 32'h10, 32'h0, LC_LW, 2'd0, "t1 lw", rd);
        chk("t1 lw value", rd, 32'hFE017F80);

        // Extension variants
        access(0, 1'b0, 32'h10, 0, LC_LB, 2'd0, "t2 lb", rd);   chk("t2 lb value", rd, 32'hFFFFFF80);
        access(0, 1'b0, 32'h10, 0, LC_LBU, 2'd0, "t2 lbu", rd); chk("t2 lbu value", rd, 32'h00000080);
        access(0, 1'b0, 32'h10, 0, LC_LH, 2'd0, "t2 lh", rd);   chk("t2 lh value", rd, 32'h00007F80);
        access(1, 1'b0, 32'h11, 0, LC_LHU, 2'd0, "t2 lhu", rd); chk("t2 lhu value", rd, 32'h0000017F);
        access(1, 1'b0, 32'h12, 0, LC_LH, 2'd0, "t2 lh12", rd); chk("t2 lh12 value", rd, 32'hFFFFFE01);

        // Simultaneous requests: round-robin order and back-to-back grant
        @(negedge clk);
        clear_events();
        set_req(0, 1'b1, 32'h20, 32'h11223344, 3'd0, SC_SW);
        set_req(1, 1'b1, 32'h30, 32'h000000AB, 3'd0, SC_SB);
        #1;
        chk("t3 first gnt", o_gnt, 2'b01);
        @(posedge clk); #1;
        t_req[0] = 1'b0;
        wait_done(0, "t3 m0", lat);
        chk("t3 m0 latency", lat, 5);
        @(negedge clk); #1;
        chk("t3 second gnt", o_gnt, 2'b10);
        @(posedge clk); #1;
        t_req[1] = 1'b0;
        wait_done(1, "t3 m1", lat);
        chk("t3 m1 latency", lat, 2);
        chk("t3 beats", ev_w.size(), 5);
        if (ev_w.size() == 5) begin
            chk("t3 byte20", {ev_a[0], ev_d[0]}, 16'h2044);
            chk("t3 byte23", {ev_a[3], ev_d[3]}, 16'h2311);
            chk("t3 byte30", {ev_w[4], ev_a[4], ev_d[4]}, 17'h130AB);
        end
        ref_store(SC_SW, 32'h20, 32'h11223344);
        ref_store(SC_SB, 32'h30, 32'hAB);
        @(negedge clk);
        set_req(0, 1'b0, 32'h20, 0, LC_LW, 2'd0);
        set_req(1, 1'b0, 32'h30, 0, LC_LBU, 2'd0);
        #1;
        chk("t3 third gnt", o_gnt, 2'b01);
        @(posedge clk); #1;
        t_req[0] = 1'b0;
        wait_done(0, "t3 m0 lw", lat);
        chk("t3 m0 lw value", o_rdata[0], 32'h11223344);
        @(negedge clk); #1;
        chk("t3 fourth gnt", o_gnt, 2'b10);
        @(posedge clk); #1;
        t_req[1] = 1'b0;
        wait_done(1, "t3 m1 lbu", lat);
        chk("t3 m1 lbu value", o_rdata[1], 32'h000000AB);

        // Address wrap at the top of the RAM
        access(0, 1'b1, 32'hFE, 32'hA1B2C3D4, 3'd0, SC_SW, "t4 sw", rd);
        access(1, 1'b0, 32'hFE, 0, LC_LW, 2'd0, "t4 lw", rd);
        chk("t4 lw value", rd, 32'hA1B2C3D4);

        // Illegal load code
        access(1, 1'b0, 32'h10, 0, 3'b011, 2'd0, "t5 ill", rd);
        chk("t5 rdata", rd, 0);
        access(0, 1'b1, 32'h10, 0, 3'd0, 2'b11, "t5 ill st", rd);

        // Reset during the third beat of a word store
        @(negedge clk);
        clear_events();
        set_req(0, 1'b1, 32'h40, 32'h5A6B7C8D, 3'd0, SC_SW);
        #1;
        chk("t6 gnt", o_gnt, 2'b01);
        @(posedge clk); #1;
        t_req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t6 beat2 strobe", {ram_we, ram_addr}, 9'h142);
        rst_n = 1'b0;
        #1;
        chk("t6 we dropped", ram_we, 0);
        chk("t6 no done", o_done, 0);
        chk("t6 rdata0 clr", o_rdata[0], 0);
        chk("t6 rdata1 clr", o_rdata[1], 0);
        ref_store(SC_SH, 32'h40, 32'h00007C8D);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b0, 32'h40, 0, LC_LW, 2'd0, "t6 lw", rd);

        // Randomized accesses against the reference model
        for (int k = 0; k < 60; k++)
            access($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), "rand", rd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Two-master controller for the byte-wide data memory of the single-cycle core.
- Arbitrates between master 0 (core load/store unit) and master 1 (debug/loader port).
- Serialises each LB/LH/LW/LBU/LHU/SB/SH/SW access into 1, 2 or 4 byte beats on a single-port synchronous RAM.
- Assembles load data little-endian and applies sign or zero extension.

Parameters:
ADDR_W, 8, RAM byte-address width (256 bytes); upper request address bits are ignored

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request; held until m0_gnt
m0_we  in  1  1 = store (use store_code), 0 = load (use load_code)
m0_addr  in  32  byte address; bits [ADDR_W-1:0] used
m0_wdata  in  32  store data, little-endian
m0_load_code  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
m0_store_code  in  2  00 SB, 01 SH, 10 SW
m0_gnt  out  1  one-cycle pulse: request accepted, inputs sampled
m0_done  out  1  one-cycle pulse: access complete
m0_rdata  out  32  load result, valid with m0_done, held until next m0_done
m0_err  out  1  illegal code, valid with m0_done
m1_*  (same set as m0_*)  master 1
ram_addr  out  ADDR_W  beat byte address
ram_wdata  out  8  beat write byte
ram_we  out  1  write strobe
ram_re  out  1  read strobe; ram_rdata returned on the next cycle
ram_rdata  in  8  read byte

Behaviour:
- Reset: state IDLE; last_grant = 1, so master 0 wins first; beat counter 0.
- Reset values: all gnt/done/err = 0, rdata = 0, ram_we = ram_re = 0, ram_addr = 0, ram_wdata = 0.
- States: IDLE, BEAT, CAPT, RESP.
- IDLE, grant rules:
  - Only one req high: grant that master.
  - Both high: grant the master not granted last.
  - On grant: pulse gnt combinationally in the same cycle; latch we, addr, wdata, code and master ID; set N = 1, 2 or 4.
  - Next state: BEAT. If the code is illegal (load 011/110/111, store 11), go straight to RESP with err = 1.
- BEAT: lasts N cycles, beat i = 0..N-1.
  - ram_addr = (addr + i) mod 2^ADDR_W, so accesses wrap at the top of the RAM.
  - Stores: ram_we = 1, ram_wdata = wdata[8i+7:8i].
  - Loads: ram_re = 1; byte i is captured the following cycle.
  - After the last beat: stores go to RESP, loads go to CAPT.
- CAPT: captures the final read byte; no RAM strobes; next state RESP.
- RESP, outputs:
  - done = 1 for the latched master.
  - rdata = assembled load value. Bytes at higher addresses are more significant.
  - Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. Stores and illegal codes give 0.
  - err = 1 only for illegal codes.
- RESP, exit: return to IDLE.
- Back-to-back: a new grant is possible in the IDLE cycle following RESP. Worst-case latency from request to done is grant cycle + N + 1 (+1 for loads).
- Latency from the gnt cycle to the done cycle: stores N+1 cycles; loads N+2 cycles; illegal codes 1 cycle.
- Request handling: req dropped before gnt means no access. Request inputs are ignored between gnt and return to IDLE. The other master's done/rdata/err do not change.
- No alignment checks: misaligned halfword/word accesses are legal and take consecutive bytes.
- Reset mid-operation: abort immediately and asynchronously.
  - RAM strobes drop at once; beats already issued stay written.
  - No done pulse; rdata cleared.

Decomposition:
- Package dmem_pkg:
  - LB/LH/LW/LBU/LHU and SB/SH/SW code constants.
  - State encoding.
  - Beat-count function (code -> 1/2/4).
  - Extension function (code + raw 32-bit value -> result).
- Sub-module rr_arb2: 2-way round-robin arbiter holding last_grant. Inputs: req[1:0] and an enable that is high in IDLE. Outputs: one-hot grant.

Test Plan:
1. RAM[0x10..0x13] = 80,7F,01,FE; m0 LW 0x10 -> gnt cycle 0, ram_re cycles 1-4 at addresses 10..13, m0_done cycle 6, m0_rdata = 0xFE017F80, err = 0.
2. Same RAM contents, successive loads:
   - LB 0x10 -> 0xFFFFFF80
   - LBU 0x10 -> 0x00000080
   - LH 0x10 -> 0x00007F80
   - LHU 0x11 -> 0x0000017F
   - LH 0x12 -> 0xFFFFFE01
3. m0 SW 0x20 wdata 0x11223344 and m1 SB 0x30 wdata 0xAB, both requesting in the same cycle:
   - m0 granted first; writes 44,33,22,11 to 20..23; m0_done 5 cycles after gnt.
   - m1 granted in the next IDLE cycle; writes AB to 30.
   - A further simultaneous request pair -> m0 granted.
4. SW 0xFE wdata 0xA1B2C3D4 -> bytes D4,C3,B2,A1 written to FE,FF,00,01 (wrap); LW 0xFE then returns 0xA1B2C3D4.
5. m1 load_code 011 -> no ram_re/ram_we; m1_done one cycle after gnt, m1_rdata = 0, m1_err = 1.
6. rst_n low during beat 2 of SW 0x40 -> ram_we drops asynchronously; only 0x40 and 0x41 written; no done; after release a new LW is granted and completes normally.
